// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
// hex_disp_pkg : character codes and active-low 7-segment patterns (gfedcba)
// Revision     : 1.0
// ============================================================================
package hex_disp_pkg;

  localparam logic [2:0] CHAR_H     = 3'd0;
  localparam logic [2:0] CHAR_E     = 3'd1;
  localparam logic [2:0] CHAR_L     = 3'd2;
  localparam logic [2:0] CHAR_O     = 3'd3;
  localparam logic [2:0] CHAR_P     = 3'd4;
  localparam logic [2:0] CHAR_U     = 3'd5;
  localparam logic [2:0] CHAR_DASH  = 3'd6;
  localparam logic [2:0] CHAR_BLANK = 3'd7;

  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  localparam logic [1:0] MODE_STATIC       = 2'b00;
  localparam logic [1:0] MODE_SCROLL       = 2'b01;
  localparam logic [1:0] MODE_BLINK        = 2'b10;
  localparam logic [1:0] MODE_SCROLL_BLINK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/seg7_char_decoder.sv
`default_nettype none
// ============================================================================
// seg7_char_decoder : 3-bit character code to active-low segment pattern
// Revision          : 1.0
// ============================================================================
module seg7_char_decoder
  import hex_disp_pkg::*;
(
  input  logic [2:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      CHAR_H:     seg = SEG_H;
      CHAR_E:     seg = SEG_E;
      CHAR_L:     seg = SEG_L;
      CHAR_O:     seg = SEG_O;
      CHAR_P:     seg = SEG_P;
      CHAR_U:     seg = SEG_U;
      CHAR_DASH:  seg = SEG_DASH;
      CHAR_BLANK: seg = SEG_BLANK;
      default:    seg = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_msg_scroller.sv
`default_nettype none
// ============================================================================
// hex_msg_scroller : scrolling / blinking message window on NUM_DIGITS displays
// Revision         : 1.0
// ============================================================================
module hex_msg_scroller
  import hex_disp_pkg::*;
#(
  parameter  int NUM_DIGITS = 6,
  parameter  int MSG_LEN    = 8,
  parameter  int DIV_MAX    = 49_999_999,
  parameter  int DIV_WIDTH  = 26,
  localparam int POS_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [3*MSG_LEN-1:0]    msg,
  input  logic [1:0]              mode,
  input  logic                    dir,
  input  logic                    restart,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [POS_W-1:0]        pos,
  output logic                    tick
);

  localparam int                   SUM_W    = 6;
  localparam int                   NSUB     = (NUM_DIGITS + MSG_LEN - 1) / MSG_LEN + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX);
  localparam logic [POS_W-1:0]     POS_LAST = POS_W'(MSG_LEN - 1);

  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    tick_q, tick_d;
  logic                    blank_ph_q, blank_ph_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [2:0]              chars [MSG_LEN];

  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d     = (div_q == DIV_LAST);
    pos_d      = pos_q;
    blank_ph_d = mode[1] ? (blank_ph_q ^ tick_q) : 1'b0;
    if (tick_q && mode[0]) begin
      if (!dir) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      else      pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
    end
    // restart wins over a tick landing in the same cycle
    if (restart) begin
      div_d      = '0;
      tick_d     = 1'b0;
      pos_d      = '0;
      blank_ph_d = 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < MSG_LEN; k++) begin : g_unpack
      assign chars[k] = msg[3*k +: 3];
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [SUM_W-1:0] idx;
      logic [2:0]       code;
      logic [6:0]       seg;

      // leftmost digit shows char pos; wrap by repeated subtraction
      always_comb begin
        idx = SUM_W'(pos_q) + SUM_W'(NUM_DIGITS - 1 - i);
        for (int s = 0; s < NSUB; s++) begin
          if (idx >= SUM_W'(MSG_LEN)) idx = idx - SUM_W'(MSG_LEN);
        end
        code = CHAR_BLANK;
        for (int k = 0; k < MSG_LEN; k++) begin
          if (idx == SUM_W'(k)) code = chars[k];
        end
      end

      seg7_char_decoder u_dec (
        .code (code),
        .seg  (seg)
      );

      assign hex_d[7*i +: 7] = blank_ph_q ? SEG_OFF : seg;
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      pos_q      <= '0;
      blank_ph_q <= 1'b0;
      hex_q      <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      pos_q      <= pos_d;
      blank_ph_q <= blank_ph_d;
      hex_q      <= hex_d;
    end
  end

  assign hex  = hex_q;
  assign pos  = pos_q;
  assign tick = tick_q;

endmodule
`default_nettype wire
